// File: rtl/nanov_serial_regfile.sv
// Bit-serial register file for nanoV: registers rotate LANE bits per enabled clock,
// with two read ports, one write port, optional rd->rs forwarding and hardwired gp/tp.
module nanov_serial_regfile #(
  parameter int              XLEN           = 32,
  parameter int              LANE           = 1,
  parameter int              NUM_REGS       = 16,
  parameter int              REG_ADDR_BITS  = 4,
  parameter int              HARDWIRE_GP_TP = 1,
  parameter logic [XLEN-1:0] GP_VALUE       = XLEN'(32'h0000_1000),
  parameter logic [XLEN-1:0] TP_VALUE       = XLEN'(32'h1000_0000),
  parameter int              BYPASS         = 1,
  localparam int             N_STEPS        = XLEN / LANE,
  localparam int             STEP_W         = (N_STEPS > 1) ? $clog2(N_STEPS) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en,
  output logic [STEP_W-1:0]        step,
  output logic                     last,
  input  logic                     wr_en,
  input  logic [REG_ADDR_BITS-1:0] rd,
  input  logic [LANE-1:0]          data_rd,
  input  logic                     read_through,
  input  logic [REG_ADDR_BITS-1:0] rs1,
  input  logic [REG_ADDR_BITS-1:0] rs2,
  output logic [LANE-1:0]          data_rs1,
  output logic [LANE-1:0]          data_rs2
);

  localparam int                NSLOT     = 2 ** REG_ADDR_BITS;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);

  logic [STEP_W-1:0]     step_q, step_d;
  logic [NSLOT*LANE-1:0] lo_flat;
  logic [NSLOT-1:0]      writable;
  logic                  fwd1, fwd2;

  always_comb begin
    step_d = step_q;
    if (en) begin
      step_d = (step_q == LAST_STEP) ? '0 : step_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end

  assign step = step_q;
  assign last = (step_q == LAST_STEP);

  // Every address slot gets a low-chunk source so the read mux never goes out of range.
  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    localparam bit IS_HARD = (HARDWIRE_GP_TP != 0) && ((i == 3) || (i == 4));
    if ((i == 0) || (i >= NUM_REGS)) begin : g_zero
      assign lo_flat[i*LANE +: LANE] = '0;
      assign writable[i]             = 1'b0;
    end else if (IS_HARD) begin : g_hard
      localparam logic [XLEN-1:0] HVAL = (i == 3) ? GP_VALUE : TP_VALUE;
      assign lo_flat[i*LANE +: LANE] = HVAL[step_q*LANE +: LANE];
      assign writable[i]             = 1'b0;
    end else begin : g_reg
      localparam logic [REG_ADDR_BITS-1:0] IDX = REG_ADDR_BITS'(i);
      logic [XLEN-1:0] reg_q, reg_d;
      logic            hit;

      assign hit = wr_en && (rd == IDX);

      // Low chunk recirculates to the top unless this register is being written.
      always_comb begin
        reg_d                  = reg_q >> LANE;
        reg_d[XLEN-1 -: LANE]  = hit ? data_rd : reg_q[LANE-1:0];
      end

      always_ff @(posedge clk) begin
        if (!rstn) begin
          reg_q <= '0;
        end else if (en) begin
          reg_q <= reg_d;
        end
      end

      assign lo_flat[i*LANE +: LANE] = reg_q[LANE-1:0];
      assign writable[i]             = 1'b1;
    end
  end

  always_comb begin
    fwd1     = (BYPASS != 0) && read_through && wr_en && (rs1 == rd) && writable[rd];
    fwd2     = (BYPASS != 0) && read_through && wr_en && (rs2 == rd) && writable[rd];
    data_rs1 = fwd1 ? data_rd : lo_flat[rs1*LANE +: LANE];
    data_rs2 = fwd2 ? data_rd : lo_flat[rs2*LANE +: LANE];
  end

endmodule

// File: tb/tb_nanov_serial_regfile.sv
// Directed bench for nanov_serial_regfile at XLEN=32, LANE=4 (8 steps per word).
module tb_nanov_serial_regfile;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic [2:0] step;
  logic       last;
  logic       wr_en;
  logic [3:0] rd;
  logic [3:0] data_rd;
  logic       read_through;
  logic [3:0] rs1, rs2;
  logic [3:0] data_rs1, data_rs2;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_beef [8] = '{4'hF, 4'hE, 4'hE, 4'hB, 4'hD, 4'hA, 4'hE, 4'hD};
  logic [3:0] exp_gp   [8] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0] exp_tp   [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};

  nanov_serial_regfile #(
    .XLEN(32), .LANE(4), .NUM_REGS(16), .REG_ADDR_BITS(4),
    .HARDWIRE_GP_TP(1), .GP_VALUE(32'h0000_1000), .TP_VALUE(32'h1000_0000), .BYPASS(1)
  ) u_dut (
    .clk(clk), .rstn(rstn), .en(en), .step(step), .last(last),
    .wr_en(wr_en), .rd(rd), .data_rd(data_rd), .read_through(read_through),
    .rs1(rs1), .rs2(rs2), .data_rs1(data_rs1), .data_rs2(data_rs2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; wr_en = 1'b0; rd = 4'd0; data_rd = 4'd0;
    read_through = 1'b0; rs1 = 4'd0; rs2 = 4'd0;
  endtask

  // Writes a full word starting at step 0; leaves step back at 0.
  task automatic write_word(input logic [3:0] addr, input logic [31:0] word, input logic thru);
    for (int k = 0; k < 8; k++) begin
      en = 1'b1; wr_en = 1'b1; rd = addr; data_rd = word[k*4 +: 4]; read_through = thru;
      tick();
    end
    wr_en = 1'b0; read_through = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    rs1 = 4'd5; rs2 = 4'd3;
    #1;
    checks++; if (step !== 3'd0) begin failures++; $display("FAIL reset_step got=%0d exp=0", step); end
    checks++; if (last !== 1'b0) begin failures++; $display("FAIL reset_last got=%0b exp=0", last); end
    checks++; if (data_rs1 !== 4'h0) begin failures++; $display("FAIL reset_x5 got=%h exp=0", data_rs1); end
    checks++; if (data_rs2 !== 4'h0) begin failures++; $display("FAIL reset_gp_chunk0 got=%h exp=0", data_rs2); end
  endtask

  task automatic test_step();
    rs1 = 4'd7;
    for (int k = 0; k < 8; k++) begin
      en = 1'b1;
      #1;
      checks++; if (step !== 3'(k)) begin failures++; $display("FAIL step_count k=%0d got=%0d exp=%0d", k, step, k); end
      checks++; if (last !== (k == 7)) begin failures++; $display("FAIL step_last k=%0d got=%0b exp=%0b", k, last, (k == 7)); end
      checks++; if (data_rs1 !== 4'h0) begin failures++; $display("FAIL step_x7 k=%0d got=%h exp=0", k, data_rs1); end
      tick();
    end
    checks++; if (step !== 3'd0) begin failures++; $display("FAIL step_wrap got=%0d exp=0", step); end
  endtask

  task automatic test_write();
    write_word(4'd5, 32'hDEAD_BEEF, 1'b0);
    rs1 = 4'd5;
    for (int k = 0; k < 8; k++) begin
      en = 1'b1;
      #1;
      checks++; if (data_rs1 !== exp_beef[k]) begin failures++; $display("FAIL write_x5 k=%0d got=%h exp=%h", k, data_rs1, exp_beef[k]); end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] word;
    word = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      en = 1'b1; wr_en = 1'b1; rd = 4'd6; data_rd = word[k*4 +: 4];
      tick();
    end
    for (int s = 0; s < 3; s++) begin
      en = 1'b0; wr_en = 1'b1; rd = 4'd6; data_rd = 4'h5;
      #1;
      checks++; if (step !== 3'd3) begin failures++; $display("FAIL stall_step s=%0d got=%0d exp=3", s, step); end
      tick();
    end
    for (int k = 3; k < 8; k++) begin
      en = 1'b1; wr_en = 1'b1; rd = 4'd6; data_rd = word[k*4 +: 4];
      tick();
    end
    wr_en = 1'b0;
    rs1 = 4'd6; rs2 = 4'd5;
    for (int k = 0; k < 8; k++) begin
      en = 1'b1;
      #1;
      checks++; if (data_rs1 !== exp_beef[k]) begin failures++; $display("FAIL stall_x6 k=%0d got=%h exp=%h", k, data_rs1, exp_beef[k]); end
      checks++; if (data_rs2 !== exp_beef[k]) begin failures++; $display("FAIL stall_x5_kept k=%0d got=%h exp=%h", k, data_rs2, exp_beef[k]); end
      tick();
    end
  endtask

  task automatic test_hardwired();
    rs1 = 4'd3; rs2 = 4'd4;
    // Write pass to x3 with forwarding requested: neither storage nor bypass may react.
    for (int k = 0; k < 8; k++) begin
      en = 1'b1; wr_en = 1'b1; rd = 4'd3; data_rd = 4'hF; read_through = 1'b1;
      #1;
      checks++; if (data_rs1 !== exp_gp[k]) begin failures++; $display("FAIL gp_during_write k=%0d got=%h exp=%h", k, data_rs1, exp_gp[k]); end
      tick();
    end
    wr_en = 1'b0; read_through = 1'b0;
    for (int k = 0; k < 8; k++) begin
      en = 1'b1;
      #1;
      checks++; if (data_rs1 !== exp_gp[k]) begin failures++; $display("FAIL gp_read k=%0d got=%h exp=%h", k, data_rs1, exp_gp[k]); end
      checks++; if (data_rs2 !== exp_tp[k]) begin failures++; $display("FAIL tp_read k=%0d got=%h exp=%h", k, data_rs2, exp_tp[k]); end
      tick();
    end
  endtask

  task automatic test_bypass();
    write_word(4'd9, 32'h0000_0003, 1'b0);
    en = 1'b0; wr_en = 1'b1; rd = 4'd9; data_rd = 4'hA; read_through = 1'b1;
    rs1 = 4'd9; rs2 = 4'd9;
    #1;
    checks++; if (data_rs1 !== 4'hA) begin failures++; $display("FAIL bypass_rs1 got=%h exp=a", data_rs1); end
    checks++; if (data_rs2 !== 4'hA) begin failures++; $display("FAIL bypass_rs2 got=%h exp=a", data_rs2); end
    rs2 = 4'd8;
    #1;
    checks++; if (data_rs1 !== 4'hA) begin failures++; $display("FAIL bypass_rs1_only got=%h exp=a", data_rs1); end
    checks++; if (data_rs2 !== 4'h0) begin failures++; $display("FAIL bypass_rs2_nomatch got=%h exp=0", data_rs2); end
    rs2 = 4'd9; read_through = 1'b0;
    #1;
    checks++; if (data_rs1 !== 4'h3) begin failures++; $display("FAIL nobypass_rs1 got=%h exp=3", data_rs1); end
    checks++; if (data_rs2 !== 4'h3) begin failures++; $display("FAIL nobypass_rs2 got=%h exp=3", data_rs2); end
    wr_en = 1'b0; read_through = 1'b1;
    #1;
    checks++; if (data_rs1 !== 4'h3) begin failures++; $display("FAIL bypass_needs_wr got=%h exp=3", data_rs1); end
    tick();
    read_through = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] word;
    word = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      en = 1'b1; wr_en = 1'b1; rd = 4'd2; data_rd = word[k*4 +: 4];
      tick();
    end
    rstn = 1'b0; en = 1'b1; wr_en = 1'b1; rd = 4'd2; data_rd = word[19:16];
    tick();
    wr_en = 1'b0; rs1 = 4'd2; rs2 = 4'd9;
    #1;
    checks++; if (step !== 3'd0) begin failures++; $display("FAIL midreset_step got=%0d exp=0", step); end
    checks++; if (last !== 1'b0) begin failures++; $display("FAIL midreset_last got=%0b exp=0", last); end
    rstn = 1'b1;
    rs2 = 4'd5;
    for (int k = 0; k < 8; k++) begin
      en = 1'b1;
      #1;
      checks++; if (data_rs1 !== 4'h0) begin failures++; $display("FAIL midreset_x2 k=%0d got=%h exp=0", k, data_rs1); end
      checks++; if (data_rs2 !== 4'h0) begin failures++; $display("FAIL midreset_x5 k=%0d got=%h exp=0", k, data_rs2); end
      tick();
    end
    rs1 = 4'd0;
    for (int k = 0; k < 8; k++) begin
      en = 1'b1; wr_en = 1'b1; rd = 4'd0; data_rd = 4'hF; read_through = 1'b1;
      #1;
      checks++; if (data_rs1 !== 4'h0) begin failures++; $display("FAIL x0_during_write k=%0d got=%h exp=0", k, data_rs1); end
      tick();
    end
    wr_en = 1'b0; read_through = 1'b0;
    for (int k = 0; k < 8; k++) begin
      en = 1'b1;
      #1;
      checks++; if (data_rs1 !== 4'h0) begin failures++; $display("FAIL x0_read k=%0d got=%h exp=0", k, data_rs1); end
      tick();
    end
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    test_reset();
    test_step();
    test_write();
    test_stall();
    test_hardwired();
    test_bypass();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
